// File: rtl/reg_bank_4x_if.sv
// reg_bank_4x_if: bundles the write handshake, the two read ports, and the
// clear/dirty status of reg_bank_4x.
//   wr_valid/wr_ready/wr_addr/wr_data : write port (valid/ready)
//   rd_addr_a/rd_data_a               : read port A (combinational)
//   rd_addr_b/rd_data_b               : read port B (combinational)
//   clr_req/clr_busy                  : clear request / clear engine active
//   dirty                             : per-entry written-since-clear mask
// The master modport is used by the requester; the slave modport is used by the bank.
interface reg_bank_4x_if #(
  parameter int unsigned WIDTH = 32
);
  logic             wr_valid;
  logic             wr_ready;
  logic [1:0]       wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic [1:0]       rd_addr_a;
  logic [WIDTH-1:0] rd_data_a;
  logic [1:0]       rd_addr_b;
  logic [WIDTH-1:0] rd_data_b;
  logic             clr_req;
  logic             clr_busy;
  logic [3:0]       dirty;

  modport master (
    output wr_valid, wr_addr, wr_data, rd_addr_a, rd_addr_b, clr_req,
    input  wr_ready, rd_data_a, rd_data_b, clr_busy, dirty
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, rd_addr_a, rd_addr_b, clr_req,
    output wr_ready, rd_data_a, rd_data_b, clr_busy, dirty
  );
endinterface

// File: rtl/reg_bank_4x.sv
// reg_bank_4x: four WIDTH-bit registers with one valid/ready write port,
// two combinational read ports (per-bit 4:1 muxes), a sequential clear
// engine that zeroes one entry per cycle, and a per-entry dirty mask.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : reg_bank_4x_if slave modport (write, read A/B, clear, dirty)

// mux4to1: single-bit 4:1 multiplexer.
//   i_d0..i_d3 : data inputs, i_sel : select, o_y : selected bit
module mux4to1 (
  input  logic       i_d0,
  input  logic       i_d1,
  input  logic       i_d2,
  input  logic       i_d3,
  input  logic [1:0] i_sel,
  output logic       o_y
);
  always_comb begin
    o_y = i_d0;
    case (i_sel)
      2'd0: o_y = i_d0;
      2'd1: o_y = i_d1;
      2'd2: o_y = i_d2;
      2'd3: o_y = i_d3;
      default: o_y = i_d0;
    endcase
  end
endmodule

module reg_bank_4x #(
  parameter int unsigned WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  reg_bank_4x_if.slave  bus
);
  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } state_t;

  state_t           r_state;
  logic [1:0]       r_clr_cnt;
  logic [WIDTH-1:0] r_regs [4];
  logic [3:0]       r_dirty;

  logic             w_wr_ready;
  logic [WIDTH-1:0] w_rd_a;
  logic [WIDTH-1:0] w_rd_b;

  assign w_wr_ready   = (r_state == ST_IDLE);
  assign bus.wr_ready = w_wr_ready;
  assign bus.clr_busy = (r_state == ST_CLEAR);
  assign bus.dirty    = r_dirty;
  assign bus.rd_data_a = w_rd_a;
  assign bus.rd_data_b = w_rd_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_clr_cnt <= '0;
      r_regs    <= '{default: '0};
      r_dirty   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // A write accepted on the same edge as clr_req still commits;
          // the clear that follows then zeroes it along with the rest.
          if (bus.wr_valid) begin
            r_regs[bus.wr_addr]  <= bus.wr_data;
            r_dirty[bus.wr_addr] <= 1'b1;
          end
          if (bus.clr_req) begin
            r_state   <= ST_CLEAR;
            r_clr_cnt <= '0;
          end
        end
        ST_CLEAR: begin
          r_regs[r_clr_cnt]  <= '0;
          r_dirty[r_clr_cnt] <= 1'b0;
          r_clr_cnt          <= r_clr_cnt + 2'd1;
          if (r_clr_cnt == 2'd3) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  for (genvar b = 0; b < WIDTH; b++) begin : g_rd_bit
    mux4to1 u_mux_a (
      .i_d0  (r_regs[0][b]),
      .i_d1  (r_regs[1][b]),
      .i_d2  (r_regs[2][b]),
      .i_d3  (r_regs[3][b]),
      .i_sel (bus.rd_addr_a),
      .o_y   (w_rd_a[b])
    );
    mux4to1 u_mux_b (
      .i_d0  (r_regs[0][b]),
      .i_d1  (r_regs[1][b]),
      .i_d2  (r_regs[2][b]),
      .i_d3  (r_regs[3][b]),
      .i_sel (bus.rd_addr_b),
      .o_y   (w_rd_b[b])
    );
  end
endmodule

// File: tb/tb_reg_bank_4x.sv
// tb_reg_bank_4x: directed testbench for reg_bank_4x.
module tb_reg_bank_4x;
  logic clk;
  logic rst_n;
  int unsigned n_checks;
  int unsigned n_fail;

  reg_bank_4x_if #(.WIDTH(32)) bus ();

  reg_bank_4x #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n         = 1'b0;
    bus.wr_valid  = 1'b0;
    bus.wr_addr   = 2'd0;
    bus.wr_data   = '0;
    bus.rd_addr_a = 2'd0;
    bus.rd_addr_b = 2'd0;
    bus.clr_req   = 1'b0;

    // Reset state
    #12;
    chk("rst_wr_ready", {31'd0, bus.wr_ready}, 32'd1);
    chk("rst_clr_busy", {31'd0, bus.clr_busy}, 32'd0);
    chk("rst_dirty", {28'd0, bus.dirty}, 32'd0);
    chk("rst_rd_a", bus.rd_data_a, 32'd0);
    chk("rst_rd_b", bus.rd_data_b, 32'd0);
    #1 rst_n = 1'b1;
    tick();

    // 1: single write, visible the next cycle, no bypass
    bus.wr_valid  = 1'b1;
    bus.wr_addr   = 2'd2;
    bus.wr_data   = 32'hDEADBEEF;
    bus.rd_addr_a = 2'd2;
    #1;
    chk("t1_no_bypass", bus.rd_data_a, 32'd0);
    tick();
    bus.wr_valid = 1'b0;
    #1;
    chk("t1_rd_a", bus.rd_data_a, 32'hDEADBEEF);
    chk("t1_dirty", {28'd0, bus.dirty}, 32'h4);

    // 2: back-to-back writes 0x11..0x44 with wr_valid held
    bus.wr_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.wr_addr = 2'(k);
      bus.wr_data = 32'(8'h11 * (k + 1));
      #1;
      chk("t2_wr_ready", {31'd0, bus.wr_ready}, 32'd1);
      tick();
      bus.rd_addr_a = 2'(k);
      #1;
      chk("t2_rd_a", bus.rd_data_a, 32'(8'h11 * (k + 1)));
    end
    bus.wr_valid  = 1'b0;
    bus.rd_addr_a = 2'd2;
    bus.rd_addr_b = 2'd2;
    #1;
    chk("t2_dirty", {28'd0, bus.dirty}, 32'hF);
    chk("t2_same_a", bus.rd_data_a, 32'h33);
    chk("t2_same_b", bus.rd_data_b, 32'h33);

    // 3: clear from a full bank; clr_req during CLEAR must be ignored
    bus.clr_req = 1'b1;
    tick();
    bus.clr_req = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (c == 1) bus.clr_req = 1'b1;
      if (c == 2) bus.clr_req = 1'b0;
      bus.rd_addr_a = 2'(c);
      bus.rd_addr_b = 2'(c - 1);
      #1;
      chk("t3_busy", {31'd0, bus.clr_busy}, 32'd1);
      chk("t3_wr_ready", {31'd0, bus.wr_ready}, 32'd0);
      chk("t3_old_val", bus.rd_data_a, 32'(8'h11 * (c + 1)));
      if (c > 0) chk("t3_cleared", bus.rd_data_b, 32'd0);
      chk("t3_dirty", {28'd0, bus.dirty}, 32'(4'hF & ~((4'd1 << c) - 4'd1)));
      tick();
    end
    bus.rd_addr_a = 2'd3;
    #1;
    chk("t3_end_busy", {31'd0, bus.clr_busy}, 32'd0);
    chk("t3_end_ready", {31'd0, bus.wr_ready}, 32'd1);
    chk("t3_end_dirty", {28'd0, bus.dirty}, 32'd0);
    chk("t3_end_reg3", bus.rd_data_a, 32'd0);
    tick();
    chk("t3_no_restart", {31'd0, bus.clr_busy}, 32'd0);

    // 4: write and clr_req together in IDLE
    bus.wr_valid  = 1'b1;
    bus.wr_addr   = 2'd3;
    bus.wr_data   = 32'hAA;
    bus.clr_req   = 1'b1;
    bus.rd_addr_a = 2'd3;
    tick();
    bus.wr_valid = 1'b0;
    bus.clr_req  = 1'b0;
    #1;
    chk("t4_rd_written", bus.rd_data_a, 32'hAA);
    chk("t4_dirty_set", {28'd0, bus.dirty}, 32'h8);
    chk("t4_busy", {31'd0, bus.clr_busy}, 32'd1);
    tick();
    tick();
    tick();
    chk("t4_reg3_c3", bus.rd_data_a, 32'hAA);
    tick();
    chk("t4_reg3_zero", bus.rd_data_a, 32'd0);
    chk("t4_dirty_clr", {28'd0, bus.dirty}, 32'd0);
    chk("t4_idle", {31'd0, bus.clr_busy}, 32'd0);

    // 5: write held through CLEAR, accepted on first IDLE cycle
    bus.clr_req = 1'b1;
    tick();
    bus.clr_req   = 1'b0;
    bus.wr_valid  = 1'b1;
    bus.wr_addr   = 2'd1;
    bus.wr_data   = 32'h55;
    bus.rd_addr_a = 2'd1;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("t5_ready_low", {31'd0, bus.wr_ready}, 32'd0);
      chk("t5_not_written", bus.rd_data_a, 32'd0);
      tick();
    end
    chk("t5_ready_high", {31'd0, bus.wr_ready}, 32'd1);
    chk("t5_pre_accept", bus.rd_data_a, 32'd0);
    tick();
    bus.wr_valid = 1'b0;
    #1;
    chk("t5_reg1", bus.rd_data_a, 32'h55);
    chk("t5_dirty", {28'd0, bus.dirty}, 32'h2);

    // 6: reset asserted mid-CLEAR
    bus.wr_valid = 1'b1;
    bus.wr_addr  = 2'd2;
    bus.wr_data  = 32'h99;
    tick();
    bus.wr_valid = 1'b0;
    bus.clr_req  = 1'b1;
    tick();
    bus.clr_req = 1'b0;
    tick();
    tick();
    bus.rd_addr_a = 2'd2;
    bus.rd_addr_b = 2'd1;
    #1;
    chk("t6_busy_before", {31'd0, bus.clr_busy}, 32'd1);
    chk("t6_reg2_before", bus.rd_data_a, 32'h99);
    rst_n = 1'b0;
    #1;
    chk("t6_busy", {31'd0, bus.clr_busy}, 32'd0);
    chk("t6_ready", {31'd0, bus.wr_ready}, 32'd1);
    chk("t6_dirty", {28'd0, bus.dirty}, 32'd0);
    chk("t6_reg2", bus.rd_data_a, 32'd0);
    chk("t6_reg1", bus.rd_data_b, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("t6_post_busy", {31'd0, bus.clr_busy}, 32'd0);
    bus.wr_valid = 1'b1;
    bus.wr_addr  = 2'd0;
    bus.wr_data  = 32'h12345678;
    bus.rd_addr_a = 2'd0;
    tick();
    bus.wr_valid = 1'b0;
    #1;
    chk("t6_post_write", bus.rd_data_a, 32'h12345678);
    chk("t6_post_dirty", {28'd0, bus.dirty}, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
